// File: rtl/common_ram_initiator_if.sv
// common_ram_initiator_if: client command/response and common_ram read/write channels
interface common_ram_initiator_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     cmd_vaild;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0]    cmd_data;
  logic                     rsp_vaild;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_error;
  logic                     bus_read_vaild;
  logic [ADDRESS_WIDTH-1:0] bus_read_address;
  logic [DATA_WIDTH-1:0]    bus_read_data;
  logic                     bus_read_ready;
  logic                     bus_write_vaild;
  logic [ADDRESS_WIDTH-1:0] bus_write_address;
  logic [DATA_WIDTH-1:0]    bus_write_data;
  logic                     bus_write_ready;
  modport master (
    input  cmd_vaild, cmd_write, cmd_address, cmd_data, rsp_ready,
           bus_read_data, bus_read_ready, bus_write_ready,
    output cmd_ready, rsp_vaild, rsp_data, rsp_error,
           bus_read_vaild, bus_read_address, bus_write_vaild, bus_write_address, bus_write_data
  );
  modport slave (
    output cmd_vaild, cmd_write, cmd_address, cmd_data, rsp_ready,
           bus_read_data, bus_read_ready, bus_write_ready,
    input  cmd_ready, rsp_vaild, rsp_data, rsp_error,
           bus_read_vaild, bus_read_address, bus_write_vaild, bus_write_address, bus_write_data
  );
endinterface

// File: rtl/common_ram_initiator.sv
// common_ram_initiator: one-at-a-time command to common_ram bus transfer; define COMMON_RAM_INITIATOR_TIMEOUT_EN for bus-ready timeout
module common_ram_initiator #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clock,
  input logic reset,
  common_ram_initiator_if.master io
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state;
  logic   done;
`ifdef COMMON_RAM_INITIATOR_TIMEOUT_EN
  logic [7:0] cnt;
`endif
  // only the channel currently being driven may complete the transfer
  always_comb done = (state == READ) ? io.bus_read_ready : io.bus_write_ready;
  // single-process FSM; every output is a register so reset forces them all low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      io.cmd_ready         <= 1'b0;
      io.rsp_vaild         <= 1'b0;
      io.rsp_data          <= '0;
      io.rsp_error         <= 1'b0;
      io.bus_read_vaild    <= 1'b0;
      io.bus_read_address  <= '0;
      io.bus_write_vaild   <= 1'b0;
      io.bus_write_address <= '0;
      io.bus_write_data    <= '0;
`ifdef COMMON_RAM_INITIATOR_TIMEOUT_EN
      cnt                  <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (io.cmd_ready && io.cmd_vaild) begin
            state                <= io.cmd_write ? WRITE : READ;
            io.cmd_ready         <= 1'b0;
            io.bus_read_vaild    <= !io.cmd_write;
            io.bus_write_vaild   <= io.cmd_write;
            io.bus_read_address  <= ADDRESS_WIDTH'(io.cmd_address);
            io.bus_write_address <= ADDRESS_WIDTH'(io.cmd_address);
            io.bus_write_data    <= io.cmd_data;
            io.rsp_error         <= 1'b0;
`ifdef COMMON_RAM_INITIATOR_TIMEOUT_EN
            cnt                  <= '0;
`endif
          end else begin
            io.cmd_ready <= 1'b1;
          end
        READ, WRITE:
          if (done) begin
            state              <= RESP;
            io.bus_read_vaild  <= 1'b0;
            io.bus_write_vaild <= 1'b0;
            io.rsp_vaild       <= 1'b1;
            io.rsp_data        <= (state == READ) ? io.bus_read_data : DATA_WIDTH'(0);
          end
`ifdef COMMON_RAM_INITIATOR_TIMEOUT_EN
          else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state              <= RESP;
            io.bus_read_vaild  <= 1'b0;
            io.bus_write_vaild <= 1'b0;
            io.rsp_vaild       <= 1'b1;
            io.rsp_data        <= '0;
            io.rsp_error       <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        RESP:
          if (io.rsp_ready) begin
            state        <= IDLE;
            io.rsp_vaild <= 1'b0;
            io.cmd_ready <= 1'b1;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_common_ram_initiator.sv
// tb_common_ram_initiator: directed checks of reset, write, read, backpressure, timeout/wait and mid-transfer reset
module tb_common_ram_initiator;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  common_ram_initiator_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) io ();
  common_ram_initiator #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock),
    .reset(reset),
    .io(io.master)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cmd(input logic w, input logic [4:0] a, input logic [31:0] d);
    io.cmd_vaild   = 1'b1;
    io.cmd_write   = w;
    io.cmd_address = a;
    io.cmd_data    = d;
    tick();
    io.cmd_vaild = 1'b0;
  endtask
  initial begin
    io.cmd_vaild = 0; io.cmd_write = 0; io.cmd_address = '0; io.cmd_data = '0;
    io.rsp_ready = 0; io.bus_read_data = '0; io.bus_read_ready = 0; io.bus_write_ready = 0;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(io.cmd_ready), 0);
    chk("rst_rsp", {29'd0, io.rsp_vaild, io.rsp_error, 1'b0}, 0);
    chk("rst_rsp_data", io.rsp_data, 0);
    chk("rst_bus_valids", {30'd0, io.bus_read_vaild, io.bus_write_vaild}, 0);
    chk("rst_bus_addr", {22'd0, io.bus_read_address, io.bus_write_address}, 0);
    chk("rst_bus_wdata", io.bus_write_data, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 32'(io.cmd_ready), 1);
    io.bus_write_ready = 1'b1;
    cmd(1'b1, 5'h00, 32'h0000_0001);
    chk("wr_valid", {30'd0, io.bus_write_vaild, io.bus_read_vaild}, 32'h2);
    chk("wr_addr", 32'(io.bus_write_address), 0);
    chk("wr_data", io.bus_write_data, 32'h1);
    chk("wr_cmd_ready_low", 32'(io.cmd_ready), 0);
    tick();
    chk("wr_valid_pulse", 32'(io.bus_write_vaild), 0);
    chk("wr_rsp", {30'd0, io.rsp_vaild, io.rsp_error}, 32'h2);
    chk("wr_rsp_data", io.rsp_data, 0);
    io.bus_write_ready = 1'b0;
    io.rsp_ready = 1'b1;
    tick();
    io.rsp_ready = 1'b0;
    chk("wr_done", {30'd0, io.rsp_vaild, io.cmd_ready}, 32'h1);
    io.bus_read_data = 32'h0000_0001;
    cmd(1'b0, 5'h00, 32'hFFFF_FFFF);
    io.bus_write_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_valid", {30'd0, io.bus_read_vaild, io.bus_write_vaild}, 32'h2);
      chk("rd_wait_no_rsp", 32'(io.rsp_vaild), 0);
      tick();
    end
    io.bus_read_ready = 1'b1;
    chk("rd_valid_cycle4", 32'(io.bus_read_vaild), 1);
    tick();
    io.bus_read_ready = 1'b0;
    io.bus_write_ready = 1'b0;
    io.bus_read_data = 32'hDEAD_0000;
    chk("rd_valid_drop", 32'(io.bus_read_vaild), 0);
    chk("rd_rsp", {30'd0, io.rsp_vaild, io.rsp_error}, 32'h2);
    chk("rd_rsp_data", io.rsp_data, 32'h1);
    io.rsp_ready = 1'b1;
    tick();
    io.rsp_ready = 1'b0;
    chk("rd_b2b_cmd_ready", 32'(io.cmd_ready), 1);
    io.bus_read_data = 32'hA5A5_1234;
    io.bus_read_ready = 1'b1;
    cmd(1'b0, 5'h1F, 32'h0);
    chk("bp_rd_addr", 32'(io.bus_read_address), 32'h1F);
    tick();
    io.bus_read_ready = 1'b0;
    io.bus_read_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {30'd0, io.rsp_vaild, io.cmd_ready}, 32'h2);
      chk("bp_rsp_data", io.rsp_data, 32'hA5A5_1234);
      tick();
    end
    io.rsp_ready = 1'b1;
    tick();
    io.rsp_ready = 1'b0;
    chk("bp_done", {30'd0, io.rsp_vaild, io.cmd_ready}, 32'h1);
    cmd(1'b1, 5'h03, 32'hDEAD_BEEF);
`ifdef COMMON_RAM_INITIATOR_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_valid_held", {30'd0, io.bus_write_vaild, io.rsp_vaild}, 32'h2);
      tick();
    end
    chk("to_valid_drop", 32'(io.bus_write_vaild), 0);
    chk("to_rsp", {30'd0, io.rsp_vaild, io.rsp_error}, 32'h3);
    chk("to_rsp_data", io.rsp_data, 0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("wait_valid_held", {30'd0, io.bus_write_vaild, io.rsp_vaild}, 32'h2);
      tick();
    end
    io.bus_write_ready = 1'b1;
    tick();
    io.bus_write_ready = 1'b0;
    chk("wait_rsp", {29'd0, io.bus_write_vaild, io.rsp_vaild, io.rsp_error}, 32'h2);
`endif
    io.rsp_ready = 1'b1;
    tick();
    io.rsp_ready = 1'b0;
    cmd(1'b0, 5'h05, 32'h0);
    chk("mid_rst_valid_before", 32'(io.bus_read_vaild), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid_async", {30'd0, io.bus_read_vaild, io.rsp_vaild}, 0);
    tick();
    reset = 1'b1;
    io.bus_read_ready = 1'b1;
    tick();
    chk("mid_rst_no_rsp", {30'd0, io.rsp_vaild, io.cmd_ready}, 32'h1);
    io.bus_read_data = 32'h0000_0077;
    cmd(1'b0, 5'h07, 32'h0);
    chk("after_rst_rd_addr", 32'(io.bus_read_address), 32'h07);
    tick();
    io.bus_read_ready = 1'b0;
    chk("after_rst_rsp", {30'd0, io.rsp_vaild, io.rsp_error}, 32'h2);
    chk("after_rst_rsp_data", io.rsp_data, 32'h77);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
